// File: rtl/key_dac_ctrl.sv
// key_dac_ctrl: converts debounced up/down/channel keys into AD5676 write
// requests. One 16-bit code is kept per channel. A press steps the selected
// channel's code, and auto-repeat runs while the key stays held. Each code
// change is handed to the SPI driver over a wr_req/wr_ack handshake.
// Optional build macro: KEY_ACCEL_EN. When defined, the step grows to
// STEP<<4 after eight auto-repeat steps.
module key_dac_ctrl #(
    parameter logic [15:0] STEP       = 16'd256,
    parameter logic [25:0] HOLD_CYC   = 26'd25_000_000,
    parameter logic [25:0] REPEAT_CYC = 26'd5_000_000,
    parameter logic [15:0] INIT_CODE  = 16'h8000
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        key_up,
    input  logic        key_down,
    input  logic        key_ch,
    input  logic        wr_ack,
    output logic        wr_req,
    output logic [2:0]  dac_ch,
    output logic [15:0] dac_code,
    output logic [2:0]  sel_ch
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t      state;
    logic [25:0] timer;
    logic [15:0] code [0:7];
    logic        prev_up, prev_down, prev_ch;
    logic        dir_up;       // latched direction of the current press
    logic        first_step;   // the last step was the press itself, not a repeat

    logic        up_press, down_press, ch_press;
    logic        start, released, at_thresh;
    logic [2:0]  target_ch;
    logic        step_up;
    logic [15:0] step_sz;
    logic [15:0] cur_code, nxt_code;
    logic [16:0] sum, diff;
    logic        changed;

`ifdef KEY_ACCEL_EN
    logic [3:0]  rpt_cnt;
    logic [20:0] big_step;
`endif

    // Falling-edge press detection, plus release/threshold decode for HOLD/REPEAT
    always_comb begin
        up_press   = prev_up   & ~key_up;
        down_press = prev_down & ~key_down;
        ch_press   = prev_ch   & ~key_ch;
        // a step starts only when exactly one of up/down is held
        start      = (up_press & key_down) | (down_press & key_up);
        // a press ends when its key is released or both direction keys go low
        released   = (dir_up ? key_up : key_down) | (~key_up & ~key_down);
        if (state == HOLD)
            at_thresh = (timer == (HOLD_CYC - 26'd1));
        else
            at_thresh = (timer == (REPEAT_CYC - 26'd1));
    end

    // Select the channel and direction that a step applies to in this cycle
    always_comb begin
        target_ch = sel_ch;
        step_up   = dir_up;
        if (state == IDLE) begin
            // a channel press in the same cycle moves the step to the new channel
            if (ch_press)
                target_ch = sel_ch + 3'd1;
            step_up = up_press;
        end
    end

`ifdef KEY_ACCEL_EN
    // Step size; switches to the large step after eight repeat steps
    always_comb begin
        big_step = {5'd0, STEP} << 4;
        if (rpt_cnt == 4'd8)
            step_sz = (big_step > 21'h00FFFF) ? 16'hFFFF : big_step[15:0];
        else
            step_sz = STEP;
    end
`else
    // Step size is fixed
    always_comb begin
        step_sz = STEP;
    end
`endif

    // Saturating step arithmetic on a 17-bit intermediate
    always_comb begin
        cur_code = code[target_ch];
        sum      = {1'b0, cur_code} + {1'b0, step_sz};
        diff     = {1'b0, cur_code} - {1'b0, step_sz};
        if (step_up)
            nxt_code = sum[16] ? 16'hFFFF : sum[15:0];
        else
            nxt_code = diff[16] ? 16'h0000 : diff[15:0];
        // a saturated result equal to the old code does not trigger a write
        changed = (nxt_code != cur_code);
    end

    // Main control FSM: key history, code storage, timer and write handshake
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            timer      <= '0;
            for (int i = 0; i < 8; i++)
                code[i] <= INIT_CODE;
            sel_ch     <= '0;
            wr_req     <= 1'b0;
            dac_ch     <= '0;
            dac_code   <= INIT_CODE;
            // history resets to released so no edge is seen on the first cycle
            prev_up    <= 1'b1;
            prev_down  <= 1'b1;
            prev_ch    <= 1'b1;
            dir_up     <= 1'b0;
            first_step <= 1'b0;
`ifdef KEY_ACCEL_EN
            rpt_cnt    <= '0;
`endif
        end else begin
            prev_up   <= key_up;
            prev_down <= key_down;
            prev_ch   <= key_ch;

            case (state)
                IDLE: begin
`ifdef KEY_ACCEL_EN
                    rpt_cnt <= '0;
`endif
                    if (ch_press)
                        sel_ch <= target_ch;
                    if (start) begin
                        dir_up     <= up_press;
                        first_step <= 1'b1;
                        timer      <= '0;
                        if (changed) begin
                            code[target_ch] <= nxt_code;
                            dac_ch          <= target_ch;
                            dac_code        <= nxt_code;
                            wr_req          <= 1'b1;
                            state           <= WRITE;
                        end
                    end
                end

                // keys are ignored and the timer is frozen until the driver accepts
                WRITE: begin
                    if (wr_ack) begin
                        wr_req <= 1'b0;
                        state  <= first_step ? HOLD : REPEAT;
                    end
                end

                HOLD, REPEAT: begin
                    if (released) begin
                        state <= IDLE;
                        timer <= '0;
                    end else if (at_thresh) begin
                        timer      <= '0;
                        first_step <= 1'b0;
`ifdef KEY_ACCEL_EN
                        if (state == REPEAT && rpt_cnt != 4'd8)
                            rpt_cnt <= rpt_cnt + 4'd1;
`endif
                        // with no change the state is kept and the timer restarts
                        if (changed) begin
                            code[target_ch] <= nxt_code;
                            dac_ch          <= target_ch;
                            dac_code        <= nxt_code;
                            wr_req          <= 1'b1;
                            state           <= WRITE;
                        end
                    end else begin
                        timer <= timer + 26'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
